fetch_unit: RTL and testbench

Instruction fetch stage for the MIPS datapath: holds the PC, requests words from instruction memory over a valid/ready handshake, and presents the registered instruction and its decoded fields to the control unit and register file. It computes the next PC from the branch/jump/zero results returned by the datapath for the accepted instruction. The `opcode` output is the direct producer of the control unit's `opcode` input.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage: PC, valid/ready imem request, registered instruction and decode.
// Define FETCH_PERF_CNT_EN to build the fetch/stall performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] jump_target, branch_target;

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign halted      = (state_q == HALT);

  assign instr  = instr_q;
  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign funct  = instr_q[5:0];
  assign imm16  = instr_q[15:0];

  // pc_q still holds the PC of the instruction in HOLD until it is accepted.
  assign pc_plus4      = pc_q + 32'd4;
  assign jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
  assign branch_target = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          if (jump) begin
            pc_d = jump_target;
          end else if (branch && zero) begin
            pc_d = branch_target;
          end else begin
            pc_d = pc_plus4;
          end
          state_d = (instr_q[31:26] == HALT_OPCODE) ? HALT : REQ;
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        fetch_evt, stall_evt;

  assign fetch_evt = (state_q == REQ) && imem_ready;
  assign stall_evt = ((state_q == REQ) && !imem_ready) || ((state_q == HOLD) && !instr_ready);

  // Saturating counters: stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (fetch_evt && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign fetch_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, randomized fetch stream against a
// PC/counter reference model, and halt/reset corner sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] pc_plus4;
  logic        jump, branch, zero;
  logic        halted;
  logic [31:0] fetch_count, stall_count;

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .HALT_OPCODE (6'b111111)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .funct       (funct),
    .imm16       (imm16),
    .pc_plus4    (pc_plus4),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .halted      (halted),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        j;
    logic        b;
    logic        z;
    int          waits;
    int          holds;
    logic [31:0] exp_next;
  } vec_t;

  vec_t        tbl [14];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  int          m_fetch;
  int          m_stall;
  logic [31:0] rw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef FETCH_PERF_CNT_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v - v);
`endif
  endfunction

  // Next PC from the accepted instruction: jump region concat, signed word offset, or +4.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] word,
                                           input logic j, input logic b, input logic z);
    logic [31:0]        p4;
    logic signed [31:0] off;
    p4 = pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ({6'd0, word[25:0]} * 32'd4);
    if (b && z) begin
      off = $signed(word[15:0]);
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  // Entered at a negedge with the DUT expected in REQ; leaves at the negedge after accept.
  task automatic do_fetch(input logic [31:0] word, input logic j, input logic b, input logic z,
                          input int waits, input int holds);
    chk("req_valid", 32'(imem_req), 32'd1);
    chk("req_addr", imem_addr, m_pc);
    chk("no_valid_in_req", 32'(instr_valid), 32'd0);
    for (int w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_stable", imem_addr, m_pc);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("no_req_in_hold", 32'(imem_req), 32'd0);
    chk("instr", instr, word);
    chk("opcode", 32'(opcode), word >> 26);
    chk("rs", 32'(rs), (word >> 21) & 32'h1F);
    chk("rt", 32'(rt), (word >> 16) & 32'h1F);
    chk("rd", 32'(rd), (word >> 11) & 32'h1F);
    chk("funct", 32'(funct), word & 32'h3F);
    chk("imm16", 32'(imm16), word & 32'hFFFF);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    for (int h = 0; h < holds; h++) begin
      instr_ready = 1'b0;
      jump        = 1'($urandom);
      branch      = 1'($urandom);
      zero        = 1'($urandom);
      @(negedge clk);
      chk("instr_stable", instr, word);
      chk("valid_held", 32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1;
    jump        = j;
    branch      = b;
    zero        = z;
    @(negedge clk);
    instr_ready = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    m_fetch += 1;
    m_stall += waits + holds;
    m_pc = ref_next(m_pc, word, j, b, z);
    chk("fetch_count", fetch_count, cnt_exp(m_fetch));
    chk("stall_count", stall_count, cnt_exp(m_stall));
  endtask

  task automatic chk_reset_state();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_fields", {opcode, rs, rt, rd, funct, 5'd0}, 32'd0);
    chk("rst_imm16", 32'(imm16), 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'h0000_0004);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_stall_count", stall_count, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{32'h8C22_0004, 1'b0, 1'b0, 1'b0, 3, 2, 32'h0000_0004};
    tbl[1]  = '{32'hAC22_0008, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0008};
    tbl[2]  = '{32'h0022_1820, 1'b0, 1'b0, 1'b0, 0, 1, 32'h0000_000C};
    tbl[3]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1, 0, 32'h0000_0010};
    tbl[4]  = '{32'h1022_FFFE, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0000_000C};
    tbl[5]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0010};
    tbl[6]  = '{32'h1022_FFFE, 1'b0, 1'b1, 1'b0, 0, 2, 32'h0000_0014};
    tbl[7]  = '{32'h0800_0040, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0000_0100};
    tbl[8]  = '{32'h0800_0000, 1'b1, 1'b0, 1'b0, 2, 0, 32'h0000_0000};
    tbl[9]  = '{32'h1000_FFFD, 1'b0, 1'b1, 1'b1, 0, 0, 32'hFFFF_FFF8};
    tbl[10] = '{32'h0800_0040, 1'b1, 1'b1, 1'b1, 0, 0, 32'hF000_0100};
    tbl[11] = '{32'h0BFF_FFFF, 1'b1, 1'b0, 1'b0, 0, 0, 32'hFFFF_FFFC};
    tbl[12] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0000};
    tbl[13] = '{32'h1000_FFFD, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0000_0004};

    rst_n       = 1'b0;
    imem_ready  = 1'b0;
    imem_rdata  = 32'd0;
    instr_ready = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state();
    rst_n = 1'b1;
    @(negedge clk);
    m_pc    = 32'h0000_0000;
    m_fetch = 0;
    m_stall = 0;

    foreach (tbl[i]) begin
      do_fetch(tbl[i].word, tbl[i].j, tbl[i].b, tbl[i].z, tbl[i].waits, tbl[i].holds);
      chk("tbl_next_addr", imem_addr, tbl[i].exp_next);
      if (i == 0) begin
        chk("first_fetch_count", fetch_count, cnt_exp(1));
        chk("first_stall_count", stall_count, cnt_exp(5));
      end
    end

    for (int k = 0; k < 60; k++) begin
      rw = $urandom;
      if (rw[31:26] == 6'b111111) rw[31:26] = 6'b000000;
      do_fetch(rw, 1'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    do_fetch(32'hFC00_0000, 1'b0, 1'b0, 1'b0, 1, 1);
    chk("halted", 32'(halted), 32'd1);
    chk("halt_no_req", 32'(imem_req), 32'd0);
    chk("halt_no_valid", 32'(instr_valid), 32'd0);
    chk("halt_pc_updated", imem_addr, m_pc);
    for (int c = 0; c < 4; c++) begin
      imem_ready  = 1'b1;
      instr_ready = 1'b1;
      @(negedge clk);
      chk("halt_sticky", 32'(halted), 32'd1);
      chk("halt_req_low", 32'(imem_req), 32'd0);
      chk("halt_fetch_count", fetch_count, cnt_exp(m_fetch));
    end
    imem_ready  = 1'b0;
    instr_ready = 1'b0;

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_state();
    @(negedge clk);
    m_pc    = 32'h0000_0000;
    m_fetch = 0;
    m_stall = 0;

    // One memory wait cycle, then reset while the request is still outstanding.
    imem_ready = 1'b0;
    @(negedge clk);
    chk("wait_stall_count", stall_count, cnt_exp(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreq_rst_req", 32'(imem_req), 32'd0);
    chk("midreq_rst_addr", imem_addr, 32'h0000_0000);
    chk("midreq_rst_fetch", fetch_count, 32'd0);
    chk("midreq_rst_stall", stall_count, 32'd0);
    @(negedge clk);
    do_fetch(32'h8C22_0004, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("recover_next_addr", imem_addr, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
